// File: rtl/ack_tx_scheduler.sv
// Transmit scheduler: queues ACK requests and arbitrates generated ACK packets
// against local data packets onto one registered output port.
module ack_tx_scheduler #(
  parameter int NODE_ID_WIDTH   = 8,
  parameter int PACKET_ID_WIDTH = 8,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int ACK_DEPTH       = 4,
  parameter int MAX_ACK_BURST   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ack_req,
  input  logic [NODE_ID_WIDTH-1:0]     ack_req_src_id,
  input  logic [PACKET_ID_WIDTH-1:0]   ack_req_packet_id,
  output logic                         ack_drop,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [NODE_ID_WIDTH-1:0]     data_dst_id,
  input  logic [PACKET_ID_WIDTH-1:0]   data_packet_id,
  input  logic [PAYLOAD_WIDTH-1:0]     data_payload,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         tx_is_ack,
  output logic [NODE_ID_WIDTH-1:0]     tx_dst_id,
  output logic [PACKET_ID_WIDTH-1:0]   tx_packet_id,
  output logic [PAYLOAD_WIDTH-1:0]     tx_payload,
  output logic [$clog2(ACK_DEPTH):0]   ack_count
);

  localparam int PW = $clog2(ACK_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_ACK_BURST + 1);

  typedef enum logic [1:0] {IDLE, SEND_ACK, SEND_DATA} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NODE_ID_WIDTH-1:0]     r_src_mem [ACK_DEPTH];
  logic [PACKET_ID_WIDTH-1:0]   r_pid_mem [ACK_DEPTH];
  logic [PW-1:0]                r_wr_ptr;
  logic [PW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [SW-1:0]                r_streak;
  logic [NODE_ID_WIDTH-1:0]     r_tx_dst;
  logic [PACKET_ID_WIDTH-1:0]   r_tx_pid;
  logic [PAYLOAD_WIDTH-1:0]     r_tx_payload;
  logic                         r_ack_drop;

  logic w_free;
  logic w_streak_ok;
  logic w_load_ack;
  logic w_load_data;
  logic w_push;

  // Pop and load are the same event; a full FIFO still accepts a push when it pops.
  always_comb begin
    w_free      = (r_state == IDLE) || tx_ready;
    w_streak_ok = r_streak < SW'(MAX_ACK_BURST);
    w_load_ack  = w_free && (r_count != '0) && (w_streak_ok || !data_valid);
    w_load_data = w_free && !w_load_ack && data_valid;
    w_push      = ack_req && ((r_count != CW'(ACK_DEPTH)) || w_load_ack);
    w_state_nxt = r_state;
    if (w_free) begin
      if (w_load_ack)       w_state_nxt = SEND_ACK;
      else if (w_load_data) w_state_nxt = SEND_DATA;
      else                  w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_src_mem[r_wr_ptr] <= ack_req_src_id;
      r_pid_mem[r_wr_ptr] <= ack_req_packet_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_streak     <= '0;
      r_tx_dst     <= '0;
      r_tx_pid     <= '0;
      r_tx_payload <= '0;
      r_ack_drop   <= 1'b0;
    end else begin
      r_ack_drop <= ack_req && !w_push;
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load_ack) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load_ack})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load_ack) begin
        if (w_streak_ok) r_streak <= r_streak + 1'b1;
        r_tx_dst     <= r_src_mem[r_rd_ptr];
        r_tx_pid     <= r_pid_mem[r_rd_ptr];
        r_tx_payload <= '0;
      end else if (w_load_data) begin
        r_streak     <= '0;
        r_tx_dst     <= data_dst_id;
        r_tx_pid     <= data_packet_id;
        r_tx_payload <= data_payload;
      end
    end
  end

  assign tx_valid     = (r_state != IDLE);
  assign tx_is_ack    = (r_state == SEND_ACK);
  assign tx_dst_id    = r_tx_dst;
  assign tx_packet_id = r_tx_pid;
  assign tx_payload   = r_tx_payload;
  assign data_ready   = w_load_data;
  assign ack_drop     = r_ack_drop;
  assign ack_count    = r_count;

endmodule

// File: tb/tb_ack_tx_scheduler.sv
// Directed bench for ack_tx_scheduler: expected packets are queued as stimulus
// is applied and compared in order at each tx handshake.
module tb_ack_tx_scheduler;

  typedef struct {
    logic        is_ack;
    logic [7:0]  dst;
    logic [7:0]  pid;
    logic [31:0] pl;
  } pkt_t;

  logic        clk;
  logic        rst_n;
  logic        ack_req;
  logic [7:0]  ack_req_src_id;
  logic [7:0]  ack_req_packet_id;
  logic        ack_drop;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  data_dst_id;
  logic [7:0]  data_packet_id;
  logic [31:0] data_payload;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_is_ack;
  logic [7:0]  tx_dst_id;
  logic [7:0]  tx_packet_id;
  logic [31:0] tx_payload;
  logic [2:0]  ack_count;

  pkt_t sb[$];
  pkt_t dq[$];
  pkt_t mon_e;
  logic taken;
  int   n_checks = 0;
  int   n_fail   = 0;

  ack_tx_scheduler #(
    .NODE_ID_WIDTH(8), .PACKET_ID_WIDTH(8), .PAYLOAD_WIDTH(32),
    .ACK_DEPTH(4), .MAX_ACK_BURST(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ack_req(ack_req), .ack_req_src_id(ack_req_src_id),
    .ack_req_packet_id(ack_req_packet_id), .ack_drop(ack_drop),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_dst_id(data_dst_id), .data_packet_id(data_packet_id),
    .data_payload(data_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_is_ack(tx_is_ack),
    .tx_dst_id(tx_dst_id), .tx_packet_id(tx_packet_id),
    .tx_payload(tx_payload), .ack_count(ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic a, input logic [7:0] d, input logic [7:0] p,
                              input logic [31:0] pl);
    pkt_t r;
    r.is_ack = a; r.dst = d; r.pid = p; r.pl = pl;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [7:0] src, input logic [7:0] id);
    ack_req = 1'b1; ack_req_src_id = src; ack_req_packet_id = id;
    tick();
    ack_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (sb.size() == 0 && dq.size() == 0 && !tx_valid) break;
      tick();
    end
    chk(tag, 64'(sb.size() + dq.size()), 64'd0);
  endtask

  // Output monitor: every handshake must match the next expected packet.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_tx: observed id 0x%0h expected none", tx_packet_id);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("tx_is_ack",    64'(tx_is_ack),    64'(mon_e.is_ack));
        chk("tx_dst_id",    64'(tx_dst_id),    64'(mon_e.dst));
        chk("tx_packet_id", 64'(tx_packet_id), 64'(mon_e.pid));
        chk("tx_payload",   64'(tx_payload),   64'(mon_e.pl));
      end
    end
  end

  // Local data source: presents dq head, advances on data_valid && data_ready.
  always @(negedge clk) taken = data_valid && data_ready;
  always @(posedge clk) begin
    #1;
    if (taken && dq.size() != 0) void'(dq.pop_front());
    taken = 1'b0;
    if (dq.size() != 0) begin
      data_valid     = 1'b1;
      data_dst_id    = dq[0].dst;
      data_packet_id = dq[0].pid;
      data_payload   = dq[0].pl;
    end else begin
      data_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ack_req = 1'b0; ack_req_src_id = '0; ack_req_packet_id = '0;
    data_valid = 1'b0; data_dst_id = '0; data_packet_id = '0; data_payload = '0;
    tx_ready = 1'b0; taken = 1'b0;
    repeat (2) tick();
    chk("rst_tx_valid",   64'(tx_valid),     64'd0);
    chk("rst_tx_is_ack",  64'(tx_is_ack),    64'd0);
    chk("rst_tx_dst",     64'(tx_dst_id),    64'd0);
    chk("rst_tx_pid",     64'(tx_packet_id), 64'd0);
    chk("rst_tx_payload", 64'(tx_payload),   64'd0);
    chk("rst_ack_count",  64'(ack_count),    64'd0);
    chk("rst_ack_drop",   64'(ack_drop),     64'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-transfer
    dq.push_back(mk(1'b0, 8'h33, 8'h77, 32'hDEADBEEF));
    for (int k = 0; k < 10 && !tx_valid; k++) tick();
    chk("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
    chk("pre_rst_tx_pid",   64'(tx_packet_id), 64'h77);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid",   64'(tx_valid),     64'd0);
    chk("mid_rst_tx_is_ack",  64'(tx_is_ack),    64'd0);
    chk("mid_rst_tx_dst",     64'(tx_dst_id),    64'd0);
    chk("mid_rst_tx_pid",     64'(tx_packet_id), 64'd0);
    chk("mid_rst_tx_payload", 64'(tx_payload),   64'd0);
    chk("mid_rst_ack_count",  64'(ack_count),    64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tx_ready = 1'b1;
    sb.push_back(mk(1'b1, 8'h12, 8'h05, 32'h0));
    ack(8'h12, 8'h05);
    tick();
    chk("first_ack_valid",   64'(tx_valid),     64'd1);
    chk("first_ack_is_ack",  64'(tx_is_ack),    64'd1);
    chk("first_ack_dst",     64'(tx_dst_id),    64'h12);
    chk("first_ack_pid",     64'(tx_packet_id), 64'h05);
    chk("first_ack_payload", 64'(tx_payload),   64'd0);
    wait_drain("drain_reset", 10);

    // Data only, back-to-back
    for (int i = 0; i < 4; i++) begin
      dq.push_back(mk(1'b0, 8'h20 + 8'(i), 8'h01 + 8'(i), 32'hA0 + 32'(i)));
      sb.push_back(mk(1'b0, 8'h20 + 8'(i), 8'h01 + 8'(i), 32'hA0 + 32'(i)));
    end
    @(negedge clk);
    for (int k = 0; k < 5 && !data_valid; k++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("data_ready_b2b", 64'(data_ready), 64'd1);
      @(negedge clk);
    end
    wait_drain("drain_data", 10);

    // ACK priority with burst limit: ACK x3, DATA, ACK
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) ack(8'h30 + 8'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) sb.push_back(mk(1'b1, 8'h30 + 8'(i), 8'h10 + 8'(i), 32'h0));
    sb.push_back(mk(1'b0, 8'h3F, 8'hD0, 32'h5555_AAAA));
    sb.push_back(mk(1'b1, 8'h33, 8'h13, 32'h0));
    chk("burst_ack_count", 64'(ack_count), 64'd3);
    dq.push_back(mk(1'b0, 8'h3F, 8'hD0, 32'h5555_AAAA));
    tx_ready = 1'b1;
    wait_drain("drain_burst", 20);

    // Backpressure with two ACKs queued and data waiting
    tx_ready = 1'b0;
    ack(8'h40, 8'h41);
    ack(8'h50, 8'h51);
    sb.push_back(mk(1'b1, 8'h40, 8'h41, 32'h0));
    sb.push_back(mk(1'b1, 8'h50, 8'h51, 32'h0));
    sb.push_back(mk(1'b0, 8'h44, 8'hD1, 32'h1234_5678));
    dq.push_back(mk(1'b0, 8'h44, 8'hD1, 32'h1234_5678));
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tx_valid",   64'(tx_valid),     64'd1);
      chk("bp_tx_pid",     64'(tx_packet_id), 64'h41);
      chk("bp_ack_count",  64'(ack_count),    64'd1);
      chk("bp_data_ready", 64'(data_ready),   64'd0);
    end
    tick();
    tx_ready = 1'b1;
    tick();
    chk("bp_next_is_ack", 64'(tx_is_ack),    64'd1);
    chk("bp_next_pid",    64'(tx_packet_id), 64'h51);
    wait_drain("drain_bp", 10);

    // Overflow, then push at full with a same-cycle pop
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ack(8'h90 + 8'(i), 8'h60 + 8'(i));
      if (i == 1) chk("ovf_first_loaded", 64'(tx_packet_id), 64'h60);
    end
    for (int i = 0; i < 5; i++) sb.push_back(mk(1'b1, 8'h90 + 8'(i), 8'h60 + 8'(i), 32'h0));
    chk("ovf_drop",       64'(ack_drop),  64'd1);
    chk("ovf_ack_count",  64'(ack_count), 64'd4);
    tick();
    chk("ovf_drop_pulse", 64'(ack_drop),  64'd0);
    chk("ovf_count_hold", 64'(ack_count), 64'd4);
    sb.push_back(mk(1'b1, 8'h96, 8'h66, 32'h0));
    tx_ready = 1'b1;
    ack(8'h96, 8'h66);
    tx_ready = 1'b0;
    chk("full_pushpop_count", 64'(ack_count),    64'd4);
    chk("full_pushpop_drop",  64'(ack_drop),     64'd0);
    chk("full_pushpop_pid",   64'(tx_packet_id), 64'h61);
    tick();
    chk("full_pushpop_drop2", 64'(ack_drop),     64'd0);
    tx_ready = 1'b1;
    wait_drain("drain_ovf", 20);

    // Wrap-around through the depth-4 FIFO
    for (int i = 0; i < 10; i++) begin
      sb.push_back(mk(1'b1, 8'hA0 + 8'(i), 8'(i), 32'h0));
      ack(8'hA0 + 8'(i), 8'(i));
    end
    wait_drain("drain_wrap", 20);
    chk("wrap_ack_count", 64'(ack_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ack_tx_scheduler.md
# ack_tx_scheduler

Transmit-side scheduler sharing one node's outgoing packet port between locally generated data packets and ACK packets for received packets that request acknowledgement. ACK requests are queued in a small FIFO, turned into ACK packets (destination = original source, packet id echoed, ack flag set, payload zero) and arbitrated against the data stream. ACKs have priority, with a burst limit that guarantees data forward progress. Sits between the receive decoder / local packet source and the link transmitter.

## Interface

- NODE_ID_WIDTH, 8, node id width
- PACKET_ID_WIDTH, 8, packet id width
- PAYLOAD_WIDTH, 32, packet payload width
- ACK_DEPTH, 4, ACK request FIFO depth (power of two, >= 2)
- MAX_ACK_BURST, 3, consecutive ACK grants allowed while data waits (>= 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ack_req  in  1  one-cycle request: enqueue an ACK for a received packet
- ack_req_src_id  in  NODE_ID_WIDTH  source id of the received packet
- ack_req_packet_id  in  PACKET_ID_WIDTH  packet id of the received packet
- ack_drop  out  1  registered pulse: an ack_req was discarded (FIFO full)
- data_valid  in  1  local data packet offered
- data_ready  out  1  data packet accepted this cycle (combinational)
- data_dst_id  in  NODE_ID_WIDTH  data packet destination
- data_packet_id  in  PACKET_ID_WIDTH  data packet id
- data_payload  in  PAYLOAD_WIDTH  data packet payload
- tx_valid  out  1  output packet valid (registered)
- tx_ready  in  1  transmitter accepts packet
- tx_is_ack  out  1  1 = ACK packet, 0 = data packet
- tx_dst_id  out  NODE_ID_WIDTH  packet destination
- tx_packet_id  out  PACKET_ID_WIDTH  packet id
- tx_payload  out  PAYLOAD_WIDTH  payload (zero for ACK)
- ack_count  out  clog2(ACK_DEPTH)+1  FIFO occupancy

## Operation

- ACK FIFO: circular buffer with wrapping read/write pointers and a count. Push on ack_req when count < ACK_DEPTH, or when count == ACK_DEPTH and a pop occurs in the same cycle. Otherwise the request is discarded and ack_drop = 1 in the next cycle. Pop happens when an ACK is loaded into the output register.
- Output register (tx_*): it is free when tx_valid == 0 or when tx_valid && tx_ready. While it is free, one source is loaded per cycle:
  - ACK when the FIFO is non-empty and (streak < MAX_ACK_BURST or data_valid == 0).
  - Otherwise data when data_valid == 1. data_ready = 1 only in this case.
  - Otherwise tx_valid goes to 0.
- While tx_valid && !tx_ready, all tx_* fields hold stable, no pop occurs, and data_ready = 0.
- ACK load: tx_is_ack = 1, tx_dst_id = queued src_id, tx_packet_id = queued packet_id, tx_payload = 0.
- Data load: tx_is_ack = 0; the remaining fields are copied from the data_* inputs.
- Streak counter (width clog2(MAX_ACK_BURST+1)):
  - +1 on each ACK load, saturating at MAX_ACK_BURST.
  - Cleared on each data load.
  - Unchanged otherwise.
- States: IDLE (tx_valid = 0), SEND_ACK, SEND_DATA. The state is given by tx_valid and tx_is_ack. Transitions occur only when the output register is free, following the selection rule above.
- Reset (any time, including mid-transfer): FIFO is emptied and pointers, count and streak are cleared. tx_valid = 0, tx_is_ack = 0, tx_dst_id = 0, tx_packet_id = 0, tx_payload = 0, ack_drop = 0, ack_count = 0. An in-flight packet is lost; no partial state is kept.

## Timing

- ACK latency: ack_req at edge N, with an empty FIFO and a free output → tx_valid = 1, tx_is_ack = 1 after edge N+1 (FIFO bypass not provided).
- Data latency: data_valid && data_ready in cycle N → tx_valid after edge N.
- Throughput: one packet per cycle when tx_ready is held high (back-to-back loads on handshake).
- ack_count reflects the registered count and updates at the edge after a push or pop.
- Simultaneous push and pop at count 0 is impossible, because pop requires a non-empty FIFO. At count == ACK_DEPTH, a same-cycle push and pop leaves count unchanged and asserts no ack_drop.
- ack_drop is high for exactly one cycle per discarded request.

## Test plan

- Reset mid-transfer:
  - Stimulus: tx_valid = 1, tx_ready = 0, assert rst_n = 0 between edges.
  - Response: tx_valid = 0, ack_count = 0 and all tx_* = 0 immediately.
  - Then: after release, a single ack_req(src = 0x12, id = 0x05) → tx_is_ack = 1, tx_dst_id = 0x12, tx_packet_id = 0x05, tx_payload = 0 two edges later.
- Data only:
  - Stimulus: tx_ready = 1, data_valid held with ids 0x01..0x04, payloads 0xA0..0xA3.
  - Response: four consecutive tx handshakes in order, tx_is_ack = 0, data_ready high every cycle.
- ACK priority with burst limit:
  - Stimulus: 4 ACKs queued, data_valid = 1, tx_ready = 1.
  - Response: output order ACK, ACK, ACK, DATA, ACK (MAX_ACK_BURST = 3).
- Backpressure:
  - Stimulus: tx_ready = 0 for 5 cycles with 2 ACKs queued.
  - Response: tx_* stable, ack_count stays 1 after the first load, data_ready = 0.
  - Then: release tx_ready → remaining ACK follows on the next cycle.
- Overflow:
  - Stimulus: 5 ack_reqs in consecutive cycles with tx_ready = 0.
  - Response: the first ACK is loaded to the output; the FIFO then fills to 4 and the 6th request (if sent) raises ack_drop.
  - Then: repeat the fill with a same-cycle pop at full → no ack_drop, ack_count stays 4.
- Wrap-around: push/pop 10 ACKs with distinct ids 0x00..0x09 through the depth-4 FIFO → output ids strictly in order, no loss, ack_count returns to 0.
